mod_n_event_counter: RTL
========================

// Module: mod_n_event_counter
// PURPOSE
//  Parametrised successor to the fixed 4-state pulse-counting FSM.
//  - Counts qualified events on x, modulo N.
//  - Asserts out while the count equals a programmable MATCH state.
//  - Pulses wrap when the count rolls over from N-1 to 0.
//  - Sits between input conditioning and control logic as a divide-by-N / event-terminal detector.
// PARAMETERS
//  N      4            modulus (number of states), legal 2..256
//  MATCH  N-1          count value that drives out high, legal 0..N-1
//  W      $clog2(N)    count width; derived, do not override
// PORTS
//  clk    in   1  rising-edge clock
//  rst    in   1  synchronous, active-high reset
//  en     in   1  event qualifier; when low, no events are counted
//  clr    in   1  synchronous clear of the count to 0
//  mode   in   1  0 = level (every cycle x=1 is an event), 1 = rising edge of x
//  x      in   1  event input, synchronous to clk
//  count  out  W  current state index, registered
//  out    out  1  (count == MATCH), Moore-decoded from the registered count
//  wrap   out  1  one-cycle registered pulse on the N-1 -> 0 rollover
// BEHAVIOUR
//  - One clock (clk). Reset is synchronous and active-high (rst). No asynchronous paths.
//  - Reset values:
//    - count = 0, wrap = 0, x_q = 0.
//    - out = (MATCH == 0).
//  - Event definition:
//    - evt = en & (mode ? (x & ~x_q) : x).
//    - x_q <= x every cycle, regardless of en, clr and mode; cleared only by rst.
//  - Priority per cycle: rst > clr > evt > hold.
//    - clr: count <= 0, wrap <= 0, even if evt is high in the same cycle.
//    - evt: count <= (count == N-1) ? 0 : count + 1; wrap <= (count == N-1).
//    - no evt: count holds, wrap <= 0.
//  - Latency:
//    - count and wrap update one clock after the qualifying x sample.
//    - out follows count combinationally, so it has no extra cycle.
//  - Edge mode:
//    - x held high counts exactly once.
//    - x high on the first cycle after rst counts as an edge, because x_q resets to 0.
//  - A mode change takes effect on the same cycle it is sampled. x_q history is kept, so switching to edge mode while x=1 and x_q=1 produces no event.
//  - Reset mid-count discards all state; counting resumes from 0 on the cycle after rst falls.
//  - Count arithmetic is W bits. Non-power-of-2 N must never reach values >= N.
//    - Any illegal count (e.g. from an SEU) recovers to 0 on the next evt and raises no wrap.
//  - Elaboration check: MATCH >= N or N < 2 is a fatal error.
// CONFIGURATION
//  - Macro: MOD_N_EVT_EDGE_EN.
//  - Defined: edge-detect logic and the x_q register are built; mode behaves as above.
//  - Undefined:
//    - x_q is not built and mode is ignored; the block is level mode only (evt = en & x).
//    - The mode port remains in the port list.
// STRUCTURE
//  - Package mod_n_evt_pkg holds:
//    - typedef enum {EVT_LEVEL = 1'b0, EVT_EDGE = 1'b1} evt_mode_t
//    - localparam defaults N_DEFAULT = 4 and MATCH_DEFAULT = 3
//  - One sub-module, evt_qualify (x, en, mode -> evt). It owns x_q and the MOD_N_EVT_EDGE_EN
//    guard, and is reused by later multi-channel variants.
//  - The counter, wrap register and out decode live in the top module.
// TESTING
//  - Tests 1-4 use N=4, MATCH=3 and build with the macro defined unless noted.
//  1. rst=1 for 2 cycles, then x=0 for 5 cycles -> count=0, out=0, wrap=0 throughout.
//  2. mode=0, en=1, x=1 for 4 cycles -> count 1,2,3,0; out=1 only while count=3;
//     wrap=1 only in the cycle count returns to 0.
//  3. mode=1, x high for 6 cycles, low 1, high 1 -> count ends at 2; no wrap.
//  4. Sequence:
//     - count=3, then clr=1 with x=1 in the same cycle -> count=0, wrap=0, out=0.
//     - count=2, then en=0 with x=1 for 3 cycles -> count holds at 2.
//  5. N=5, MATCH=0, level mode: after rst, out=1; drive x=1 for 5 cycles -> count 1,2,3,4,0;
//     wrap on the 5th; out=1 again.
//  6. rst=1 asserted while count=2 with x=1 -> next cycle count=0, out=0, wrap=0.
//     Repeat test 3 with the macro undefined -> counts every x=1 cycle (ends at 3 after 7 highs).

Source files
------------

// File: rtl/mod_n_evt_pkg.sv
// Shared types and defaults for the modulo-N event counter family.
package mod_n_evt_pkg;

   typedef enum logic {EVT_LEVEL = 1'b0, EVT_EDGE = 1'b1} evt_mode_t;

   localparam int N_DEFAULT     = 4;
   localparam int MATCH_DEFAULT = 3;

endpackage

// File: rtl/evt_qualify.sv
// Event qualifier: turns raw x into a one-cycle event strobe.
// With MOD_N_EVT_EDGE_EN defined, mode selects level or rising-edge events and
// the x history register is built. Without it the block is level-only and
// mode is ignored (the port stays so callers need not change).
module evt_qualify
   import mod_n_evt_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic mode,
   input  logic x,
   output logic evt
);

`ifdef MOD_N_EVT_EDGE_EN
   logic x_q;

   // x history, sampled every cycle; only reset clears it so edges survive en/clr/mode
   always_ff @(posedge clk) begin
      if (rst) x_q <= 1'b0;
      else     x_q <= x;
   end

   assign evt = en & ((evt_mode_t'(mode) == EVT_EDGE) ? (x & ~x_q) : x);
`else
   logic unused_edge;
   assign unused_edge = ^{clk, rst, mode};

   assign evt = en & x;
`endif

endmodule

// File: rtl/mod_n_event_counter.sv
// Modulo-N qualified event counter with terminal-state decode and rollover pulse.
// Optional edge-detect events are enabled by defining MOD_N_EVT_EDGE_EN.
module mod_n_event_counter
   import mod_n_evt_pkg::*;
#(
   parameter int N     = N_DEFAULT,
   parameter int MATCH = MATCH_DEFAULT,
   parameter int W     = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         clr,
   input  logic         mode,
   input  logic         x,
   output logic [W-1:0] count,
   output logic         out,
   output logic         wrap
);

   generate
      if (N < 2 || MATCH < 0 || MATCH >= N) begin : g_bad_cfg
         $fatal(1, "mod_n_event_counter: illegal N=%0d / MATCH=%0d", N, MATCH);
      end
   endgenerate

   localparam logic [W-1:0] LAST    = W'(N - 1);
   localparam logic [W-1:0] MATCH_C = W'(MATCH);

   logic evt;
   logic over;

   evt_qualify u_qual (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .mode (mode),
      .x    (x),
      .evt  (evt)
   );

   // Out-of-range count (only reachable by upset when N is not a power of 2)
   generate
      if ((1 << W) == N) begin : g_pow2
         assign over = 1'b0;
      end else begin : g_npow2
         assign over = (count > LAST);
      end
   endgenerate

   // Count state and rollover pulse: rst > clr > evt > hold
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         wrap  <= 1'b0;
      end else if (clr) begin
         count <= '0;
         wrap  <= 1'b0;
      end else if (evt) begin
         if (count == LAST) begin
            count <= '0;
            wrap  <= 1'b1;
         end else if (over) begin
            count <= '0;
            wrap  <= 1'b0;
         end else begin
            count <= count + 1'b1;
            wrap  <= 1'b0;
         end
      end else begin
         wrap <= 1'b0;
      end
   end

   assign out = (count == MATCH_C);

endmodule
